neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
- Single-neuron multiply-accumulate sequencer that sits directly downstream of one per-neuron weight BRAM (layer 0, 28 words × 16 bit).
- On a start pulse it walks the shared weight/input address space and accumulates weight × activation over N_IN terms. Word N_IN of the weight BRAM holds the bias.
- It then rounds, saturates and optionally rectifies the sum, and presents one 16-bit activation to the next layer through a valid/ready handshake.

Parameters:
- N_IN, 27, number of weighted inputs; the bias is at weight address N_IN.
- ADDR_W, 5, width of mem_addr; must satisfy 2^ADDR_W > N_IN.
- DATA_W, 16, width of weights, activations and output (signed two's complement).
- FRAC_BITS, 8, fractional bits of the Q-format shared by weights, activations and output.
- ACC_W, 40, accumulator width (signed).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to evaluate the neuron.
- busy  out  1  high from start acceptance until the output handshake completes.
- mem_addr  out  ADDR_W  address to weight BRAM and input-activation buffer.
- mem_en  out  1  read enable to weight BRAM.
- mem_we  out  1  weight BRAM write enable; constant 0.
- x_en  out  1  read enable to input buffer; low on the bias address.
- w_do  in  DATA_W  weight BRAM read data.
- x_data  in  DATA_W  input-activation read data.
- out_data  out  DATA_W  neuron result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- sat  out  1  the result was clipped; valid with out_valid.

Behaviour:
- Reset (RST_N=0 at posedge): state IDLE; busy, mem_en, x_en, out_valid and sat are 0; mem_addr, out_data and the accumulator are 0. Reset mid-operation aborts immediately with no partial output.
- Memory timing: the weight BRAM samples on negedge. Data for an address issued in cycle k is valid at posedge k+1, and the block captures it there. The input buffer has the same one-cycle latency.
- States: IDLE → FETCH → LAST → RESULT → IDLE.
- IDLE: start=1 is accepted at the posedge; acc←0, mem_addr←0, mem_en←1, x_en←1, busy←1, next state FETCH.
- FETCH:
  - Each cycle mem_addr increments by 1.
  - At each posedge after the first issue, acc ← acc + sext(w_do × x_data), a full 2·DATA_W product.
  - When the issued address equals N_IN (bias): x_en=0 and next state LAST.
- LAST: mem_en←0. Capture the bias: acc ← acc + (sext(w_do) <<< FRAC_BITS). Next state RESULT.
- RESULT:
  - r = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS, i.e. round half up.
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; sat=1 if clipped.
  - Register the result into out_data and set out_valid=1.
  - Hold until out_valid && out_ready, then out_valid←0, busy←0, next state IDLE.
- Latency: acceptance at edge T0 → out_valid at edge T0+N_IN+3 (30 cycles at the defaults).
- start while busy=1 is ignored, including while out_valid is waiting.
- start in the cycle of the output handshake is ignored; it is accepted from IDLE on the next cycle.
- out_data and sat stay stable while out_valid=1 && out_ready=0.
- mem_addr never exceeds N_IN and never wraps.

Optional Feature:
- Macro: NEURON_MAC_RELU_EN.
- Defined: after saturation, negative results become 0. sat reflects saturation only, not the rectification.
- Undefined: linear output, negative values passed through.

Decomposition:
- Package neuron_pkg: DATA_W, FRAC_BITS, ACC_W defaults; state enum (IDLE, FETCH, LAST, RESULT); saturation limit constants.
- One sub-module, neuron_round_sat: combinational round, saturate and optional ReLU, ACC_W in → DATA_W out plus sat. Keeps the arithmetic unit-testable on its own.

Test Plan:
- All 27 weights 0x0100, all x 0x0100, bias 0x0000 → out_data 0x1B00 (27.0), sat=0, out_valid exactly 30 cycles after start.
- Weights 0xFF00 (−1.0), x 0x0100, bias 0 → out_data 0xE500 without NEURON_MAC_RELU_EN; 0x0000 with it defined.
- Weights and x all 0x7FFF, bias 0x7FFF → out_data 0x7FFF, sat=1; all weights 0x8000 with x 0x7FFF → 0x8000, sat=1 (without ReLU).
- Weights 0, bias 0x0280 → out_data 0x0280. Single weight 0x0001 with x 0x0080 → rounding yields 0x0001.
- out_ready low for 5 cycles after out_valid, with a start pulse inserted → out_data and sat stable, start ignored, busy=1; completion after out_ready rises.
- RST_N low for one cycle while mem_addr=10 → next cycle all outputs 0 and state IDLE; a following start gives the same result as a clean run.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths, FSM encoding and output clip limits for the neuron MAC sequencer.
package neuron_pkg;

    localparam int NM_DATA_W    = 16;
    localparam int NM_FRAC_BITS = 8;
    localparam int NM_ACC_W     = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LAST   = 2'd2,
        RESULT = 2'd3
    } state_e;

    localparam logic signed [NM_DATA_W-1:0] SAT_MAX = {1'b0, {(NM_DATA_W-1){1'b1}}};
    localparam logic signed [NM_DATA_W-1:0] SAT_MIN = {1'b1, {(NM_DATA_W-1){1'b0}}};

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Request, weight/activation memory and result handshake bundle of one neuron.
interface neuron_mac_seq_if
    import neuron_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = NM_DATA_W
);
    logic              start;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic              x_en;
    logic [DATA_W-1:0] w_do;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sat;

    // slave = the neuron; master = controller, memories and downstream layer
    modport slave (
        input  start, w_do, x_data, out_ready,
        output busy, mem_addr, mem_en, mem_we, x_en, out_data, out_valid, sat
    );
    modport master (
        output start, w_do, x_data, out_ready,
        input  busy, mem_addr, mem_en, mem_we, x_en, out_data, out_valid, sat
    );
endinterface

// File: rtl/neuron_round_sat.sv
// Round-half-up, saturate and (with NEURON_MAC_RELU_EN defined) rectify the accumulator.
module neuron_round_sat
    import neuron_pkg::*;
#(
    parameter int ACC_W     = NM_ACC_W,
    parameter int DATA_W    = NM_DATA_W,
    parameter int FRAC_BITS = NM_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [DATA_W-1:0]       res_o,
    output logic                    sat_o
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_BITS - 1);

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] r;
    logic [DATA_W-1:0]       clip;

    assign rnd = acc_i + HALF;
    assign r   = rnd >>> FRAC_BITS;

    // r fits iff every bit above the output sign bit matches it
    assign sat_o = !((&r[ACC_W-1:DATA_W-1]) || !(|r[ACC_W-1:DATA_W-1]));
    assign clip  = sat_o ? (r[ACC_W-1] ? SAT_MIN : SAT_MAX) : r[DATA_W-1:0];

`ifdef NEURON_MAC_RELU_EN
    assign res_o = clip[DATA_W-1] ? '0 : clip;
`else
    assign res_o = clip;
`endif

endmodule

// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer: walks N_IN weight/input pairs plus a bias word, then emits one activation.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_IN      = 27,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = NM_DATA_W,
    parameter int FRAC_BITS = NM_FRAC_BITS,
    parameter int ACC_W     = NM_ACC_W
) (
    input  logic           CLK,
    input  logic           RST_N,
    neuron_mac_seq_if.slave bus
);
    localparam logic [ADDR_W-1:0] BIAS_A = ADDR_W'(N_IN);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    mem_en_q, mem_en_d;
    logic                    x_en_q, x_en_d;
    logic                    busy_q, busy_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sat_q, sat_d;
    logic [DATA_W-1:0]       out_q, out_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic [DATA_W-1:0]          rs_res;
    logic                       rs_sat;

    assign prod     = $signed(bus.w_do) * $signed(bus.x_data);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'($signed(bus.w_do)) <<< FRAC_BITS;

    neuron_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_rs (
        .acc_i (acc_q),
        .res_o (rs_res),
        .sat_o (rs_sat)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (addr_q == BIAS_A) state_d = LAST;
            LAST:    state_d = RESULT;
            RESULT:  if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data at each edge belongs to the address held during the preceding cycle.
    always_comb begin
        acc_d       = acc_q;
        addr_d      = addr_q;
        mem_en_d    = mem_en_q;
        x_en_d      = x_en_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        out_d       = out_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                acc_d    = '0;
                addr_d   = '0;
                mem_en_d = 1'b1;
                x_en_d   = (BIAS_A != '0);
                busy_d   = 1'b1;
            end
            FETCH: if (addr_q != BIAS_A) begin
                acc_d  = acc_q + prod_ext;
                addr_d = addr_q + 1'b1;
                x_en_d = ((addr_q + 1'b1) != BIAS_A);
            end
            LAST: begin
                acc_d    = acc_q + bias_ext;
                mem_en_d = 1'b0;
            end
            RESULT: begin
                if (!out_valid_q) begin
                    out_d       = rs_res;
                    sat_d       = rs_sat;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_q       <= '0;
            addr_q      <= '0;
            mem_en_q    <= 1'b0;
            x_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            mem_en_q    <= mem_en_d;
            x_en_q      <= x_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            out_q       <= out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = 1'b0;
    assign bus.x_en      = x_en_q;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed-vector bench for neuron_mac_seq with behavioural weight BRAM and input buffer.
module tb_neuron_mac_seq;
    localparam int N_IN = 27;

    typedef struct {
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] b;
        int          nw;
        logic [15:0] exp_out;
        logic        exp_sat;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] w_mem [0:31];
    logic [15:0] x_mem [0:31];
    vec_t        tv [9];

    neuron_mac_seq_if bus ();

    neuron_mac_seq dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.mem_en) bus.w_do   <= w_mem[bus.mem_addr];
        if (bus.x_en)   bus.x_data <= x_mem[bus.mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus.mem_en === 1'b1) begin
            chk("addr_range", 32'(bus.mem_addr <= 5'd27), 32'd1);
            if (bus.mem_addr == 5'd27) chk("x_en_on_bias", 32'(bus.x_en), 32'd0);
        end
    end

    task automatic load(input vec_t v);
        for (int i = 0; i < N_IN; i++) begin
            w_mem[i] = (i < v.nw) ? v.w : 16'h0000;
            x_mem[i] = v.x;
        end
        w_mem[N_IN] = v.b;
        x_mem[N_IN] = 16'hDEAD;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    task automatic finish_hs(input string nm);
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        chk({nm, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({nm, ".busy_drop"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc;
        load(v);
        pulse_start();
        chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
        wait_valid(cyc);
        chk({nm, ".latency"}, 32'(cyc), 32'd30);
        chk({nm, ".out"}, 32'(bus.out_data), 32'(v.exp_out));
        chk({nm, ".sat"}, 32'(bus.sat), 32'(v.exp_sat));
        finish_hs(nm);
    endtask

    initial begin
        int cyc;
        int n;

        tv[0] = '{16'h0100, 16'h0100, 16'h0000, 27, 16'h1B00, 1'b0};
`ifdef NEURON_MAC_RELU_EN
        tv[1] = '{16'hFF00, 16'h0100, 16'h0000, 27, 16'h0000, 1'b0};
        tv[3] = '{16'h8000, 16'h7FFF, 16'h0000, 27, 16'h0000, 1'b1};
        tv[8] = '{16'hFFFF, 16'h0081, 16'h0000, 1,  16'h0000, 1'b0};
`else
        tv[1] = '{16'hFF00, 16'h0100, 16'h0000, 27, 16'hE500, 1'b0};
        tv[3] = '{16'h8000, 16'h7FFF, 16'h0000, 27, 16'h8000, 1'b1};
        tv[8] = '{16'hFFFF, 16'h0081, 16'h0000, 1,  16'hFFFF, 1'b0};
`endif
        tv[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 27, 16'h7FFF, 1'b1};
        tv[4] = '{16'h0000, 16'h0100, 16'h0280, 27, 16'h0280, 1'b0};
        tv[5] = '{16'h0001, 16'h0080, 16'h0000, 1,  16'h0001, 1'b0};
        tv[6] = '{16'h0080, 16'h0100, 16'hFF00, 27, 16'h0C80, 1'b0};
        tv[7] = '{16'hFFFF, 16'h0080, 16'h0000, 1,  16'h0000, 1'b0};

        for (int i = 0; i < 32; i++) begin
            w_mem[i] = 16'h0;
            x_mem[i] = 16'h0;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.w_do      = 16'h0;
        bus.x_data    = 16'h0;
        RST_N         = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst.x_en", 32'(bus.x_en), 32'd0);
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.out", 32'(bus.out_data), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // backpressure: hold result 5 cycles with a stray start pulse
        load(tv[0]);
        pulse_start();
        wait_valid(cyc);
        chk("bp.latency", 32'(cyc), 32'd30);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 2);
            @(posedge CLK); #1;
            chk($sformatf("bp.out%0d", k), 32'(bus.out_data), 32'h1B00);
            chk($sformatf("bp.sat%0d", k), 32'(bus.sat), 32'd0);
            chk($sformatf("bp.valid%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp.busy%0d", k), 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        finish_hs("bp");
        @(posedge CLK); #1;
        chk("bp.idle_after", 32'(bus.busy), 32'd0);

        // start during the handshake cycle is dropped, accepted one cycle later
        load(tv[1]);
        pulse_start();
        wait_valid(cyc);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        chk("hs.start_ignored", 32'(bus.busy), 32'd0);
        @(posedge CLK); #1;
        bus.start = 1'b0;
        chk("hs.start_taken", 32'(bus.busy), 32'd1);
        wait_valid(cyc);
        chk("hs.latency", 32'(cyc), 32'd30);
        chk("hs.out", 32'(bus.out_data), 32'(tv[1].exp_out));
        finish_hs("hs");

        // reset mid-run at address 10, then a clean rerun
        load(tv[0]);
        pulse_start();
        n = 0;
        while (bus.mem_addr !== 5'd10 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mid.addr10", 32'(bus.mem_addr), 32'd10);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        chk("mid.busy", 32'(bus.busy), 32'd0);
        chk("mid.mem_en", 32'(bus.mem_en), 32'd0);
        chk("mid.x_en", 32'(bus.x_en), 32'd0);
        chk("mid.addr", 32'(bus.mem_addr), 32'd0);
        chk("mid.out", 32'(bus.out_data), 32'd0);
        chk("mid.valid", 32'(bus.out_valid), 32'd0);
        chk("mid.sat", 32'(bus.sat), 32'd0);
        @(posedge CLK); #1;
        chk("mid.still_idle", 32'(bus.busy), 32'd0);
        run_vec(tv[0], "rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
